mul4_dot_accumulator: RTL and testbench

//   Sequential dot-product stage downstream of the 4x4 array multiplier.
//   - Consumes one 8-bit product P per accepted beat.
//   - Sums LEN consecutive products into an ACC_W-bit accumulator.
//   - Presents the finished sum on a valid/ready output port.
//   - Turns the combinational multiplier into a streaming MAC datapath.

---
 rtl/mul4_dot_accumulator.sv | 105 ++++++++++
 tb/tb_mul4_dot_accumulator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul4_dot_accumulator.sv
// mul4_dot_accumulator: streaming dot-product accumulator for 4x4 products.
// Sums LEN consecutive 8-bit products into an ACC_W-bit result presented on
// a valid/ready port. Carry-out of any addition sets a sticky overflow flag.
// Optional feature macro: MUL4_DOT_SAT_EN (saturate at 2^ACC_W-1 on overflow
// instead of wrapping modulo 2^ACC_W).
module mul4_dot_accumulator #(
  parameter int LEN   = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] p;
  logic [ACC_W-1:0] sum_val;
  logic [ACC_W:0]   sum_ext;
  logic             ovf, ovf_d, carry;
  logic             first, last, accept;

  assign p        = ACC_W'(in_p);
  assign first    = (count == '0);
  assign last     = (count == LAST);
  assign in_ready = (state != DONE);
  assign accept   = in_valid & in_ready & ~clr;
  assign busy     = (count != '0) | (state == DONE);

  // Next accumulator value and overflow; the first beat loads p and restarts ovf
  always_comb begin
    sum_ext = first ? {1'b0, p} : ({1'b0, acc} + {1'b0, p});
    carry   = sum_ext[ACC_W];
    ovf_d   = (first ? 1'b0 : ovf) | carry;
`ifdef MUL4_DOT_SAT_EN
    // once overflowed the value is pinned at full scale for the rest of the product
    sum_val = ovf_d ? '1 : sum_ext[ACC_W-1:0];
`else
    sum_val = sum_ext[ACC_W-1:0];
`endif
  end

  // Next-state logic; clr overrides every other transition
  always_comb begin
    state_d = state;
    case (state)
      IDLE, ACC: if (accept) state_d = last ? DONE : ACC;
      DONE:      if (out_valid && out_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Datapath: beat counter, accumulator, sticky overflow and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr) begin
      count     <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      acc <= sum_val;
      ovf <= ovf_d;
      if (last) begin
        count     <= '0;
        out_sum   <= sum_val;
        out_ovf   <= ovf_d;
        out_valid <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul4_dot_accumulator.sv
// Testbench for mul4_dot_accumulator: table vectors, directed corner cases and
// random dot products checked against an arithmetic reference model.
module tb_mul4_dot_accumulator;

`ifdef MUL4_DOT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, out_ready;
  logic [7:0]  in_p;
  logic        a_in_ready, a_out_valid, a_out_ovf, a_busy;
  logic [15:0] a_out_sum;
  logic        b_in_ready, b_out_valid, b_out_ovf, b_busy;
  logic [8:0]  b_out_sum;
  logic        c_valid, c_ready, c_in_ready, c_out_valid, c_out_ovf, c_busy;
  logic [7:0]  c_p;
  logic [15:0] c_out_sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul4_dot_accumulator #(.LEN(4), .ACC_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_p(in_p), .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
    .out_ovf(a_out_ovf), .busy(a_busy));

  mul4_dot_accumulator #(.LEN(4), .ACC_W(9)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_p(in_p), .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
    .out_ovf(b_out_ovf), .busy(b_busy));

  mul4_dot_accumulator #(.LEN(1), .ACC_W(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(c_valid), .in_ready(c_in_ready),
    .in_p(c_p), .out_valid(c_out_valid), .out_ready(c_ready), .out_sum(c_out_sum),
    .out_ovf(c_out_ovf), .busy(c_busy));

  typedef struct {
    int p[4];
    int e16;
    int o16;
    int e9w;
    int o9;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: true integer sum, overflow iff it reaches 2^w
  function automatic void model(input int p[4], input int w, output int sum, output int ovf);
    int total;
    int lim;
    total = 0;
    lim = 1 << w;
    for (int i = 0; i < 4; i++) total += p[i];
    if (total >= lim) begin
      ovf = 1;
      sum = SAT ? lim - 1 : total % lim;
    end else begin
      ovf = 0;
      sum = total;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int p[4], input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      in_valid = 1'b1;
      in_p = 8'(p[i]);
      chk("in_ready_before_beat", int'(a_in_ready), 1);
      tick();
      if (i < 3) begin
        chk("no_early_valid", int'(a_out_valid), 0);
        chk("busy_mid", int'(a_busy), 1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_dot(input int p[4], input int e16, input int o16, input int e9,
                         input int o9, input bit gaps, input int hold);
    feed(p, gaps);
    chk("a_valid", int'(a_out_valid), 1);
    chk("a_sum", int'(a_out_sum), e16);
    chk("a_ovf", int'(a_out_ovf), o16);
    chk("b_valid", int'(b_out_valid), 1);
    chk("b_sum", int'(b_out_sum), e9);
    chk("b_ovf", int'(b_out_ovf), o9);
    chk("a_in_ready_done", int'(a_in_ready), 0);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_valid", int'(a_out_valid), 1);
      chk("hold_sum", int'(a_out_sum), e16);
      chk("hold_b_sum", int'(b_out_sum), e9);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_valid", int'(a_out_valid), 0);
    chk("post_hs_in_ready", int'(a_in_ready), 1);
    chk("post_hs_busy", int'(a_busy), 0);
    chk("post_hs_ovf", int'(b_out_ovf), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int rp[4];
    int e16, o16, e9, o9;

    tbl[0].p = '{225, 225, 225, 225}; tbl[0].e16 = 900; tbl[0].o16 = 0; tbl[0].e9w = 388; tbl[0].o9 = 1;
    tbl[1].p = '{0, 0, 0, 0};         tbl[1].e16 = 0;   tbl[1].o16 = 0; tbl[1].e9w = 0;   tbl[1].o9 = 0;
    tbl[2].p = '{1, 2, 3, 4};         tbl[2].e16 = 10;  tbl[2].o16 = 0; tbl[2].e9w = 10;  tbl[2].o9 = 0;
    tbl[3].p = '{100, 200, 150, 50};  tbl[3].e16 = 500; tbl[3].o16 = 0; tbl[3].e9w = 500; tbl[3].o9 = 0;
    tbl[4].p = '{200, 200, 112, 0};   tbl[4].e16 = 512; tbl[4].o16 = 0; tbl[4].e9w = 0;   tbl[4].o9 = 1;
    tbl[5].p = '{225, 225, 61, 0};    tbl[5].e16 = 511; tbl[5].o16 = 0; tbl[5].e9w = 511; tbl[5].o9 = 0;

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_p = '0; out_ready = 1'b0;
    c_valid = 1'b0; c_p = '0; c_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", int'(a_in_ready), 1);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_valid", int'(a_out_valid), 0);
    chk("rst_sum", int'(a_out_sum), 0);
    chk("rst_ovf", int'(a_out_ovf), 0);
    chk("rst_c_valid", int'(c_out_valid), 0);
    tick();

    // Table vectors, back-to-back beats
    for (int v = 0; v < 6; v++)
      run_dot(tbl[v].p, tbl[v].e16, tbl[v].o16,
              (SAT && tbl[v].o9 != 0) ? 511 : tbl[v].e9w, tbl[v].o9, 1'b0, 0);

    // Backpressure with extra in_valid beats offered while DONE
    feed('{10, 20, 30, 40}, 1'b0);
    in_valid = 1'b1;
    in_p = 8'd99;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", int'(a_out_valid), 1);
      chk("bp_sum", int'(a_out_sum), 100);
      chk("bp_in_ready", int'(a_in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", int'(a_out_valid), 0);
    chk("bp_release_in_ready", int'(a_in_ready), 1);
    chk("bp_release_busy", int'(a_busy), 0);
    run_dot('{1, 2, 3, 4}, 10, 0, 10, 0, 1'b0, 0);

    // clr with the second beat drops it and the partial sum
    in_valid = 1'b1;
    in_p = 8'd10;
    tick();
    in_p = 8'd20;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_busy", int'(a_busy), 0);
    chk("clr_valid", int'(a_out_valid), 0);
    repeat (3) tick();
    chk("clr_no_output", int'(a_out_valid), 0);
    run_dot('{1, 2, 3, 4}, 10, 0, 10, 0, 1'b0, 0);

    // clr in DONE beats a same-cycle handshake and drops the result
    feed('{5, 6, 7, 8}, 1'b0);
    chk("clr_done_valid_before", int'(a_out_valid), 1);
    clr = 1'b1;
    out_ready = 1'b1;
    tick();
    clr = 1'b0;
    out_ready = 1'b0;
    chk("clr_done_valid", int'(a_out_valid), 0);
    chk("clr_done_in_ready", int'(a_in_ready), 1);
    chk("clr_done_busy", int'(a_busy), 0);

    // Asynchronous reset mid-accumulation
    in_valid = 1'b1;
    in_p = 8'd50;
    tick();
    in_p = 8'd60;
    tick();
    in_valid = 1'b0;
    chk("areset_busy_before", int'(a_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", int'(a_out_valid), 0);
    chk("areset_busy", int'(a_busy), 0);
    chk("areset_sum", int'(a_out_sum), 0);
    #2 rst_n = 1'b1;
    run_dot('{5, 5, 5, 5}, 20, 0, 20, 0, 1'b0, 0);

    // Randomized dot products with gaps and backpressure
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) rp[i] = int'($urandom_range(0, 225));
      model(rp, 16, e16, o16);
      model(rp, 9, e9, o9);
      run_dot(rp, e16, o16, e9, o9, 1'b1, int'($urandom_range(0, 3)));
    end

    // LEN=1: one beat per product, one accepted every other cycle
    c_valid = 1'b1;
    c_p = 8'd7;
    c_ready = 1'b1;
    tick();
    chk("len1_valid0", int'(c_out_valid), 1);
    chk("len1_sum0", int'(c_out_sum), 7);
    chk("len1_ovf0", int'(c_out_ovf), 0);
    chk("len1_in_ready_done", int'(c_in_ready), 0);
    c_p = 8'd9;
    tick();
    chk("len1_hs_valid", int'(c_out_valid), 0);
    chk("len1_hs_in_ready", int'(c_in_ready), 1);
    chk("len1_hs_sum_held", int'(c_out_sum), 7);
    tick();
    c_valid = 1'b0;
    chk("len1_valid1", int'(c_out_valid), 1);
    chk("len1_sum1", int'(c_out_sum), 9);
    tick();
    c_ready = 1'b0;
    chk("len1_end_valid", int'(c_out_valid), 0);
    chk("len1_end_busy", int'(c_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
